// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm ringer block.
package alarm_pkg;
    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;
    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_e;

    function automatic logic set_point_ok(input logic [HOUR_W-1:0] h,
                                          input logic [MIN_W-1:0]  m);
        return (h <= HOUR_W'(MAX_HOUR)) && (m <= MIN_W'(MAX_MIN));
    endfunction
endpackage

// File: rtl/alarm_tone_gen.sv
// Tone square wave: half-period of TONE_DIV clocks, restarts high on start_i,
// held low whenever not enabled.
module alarm_tone_gen #(
    parameter int TONE_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic start_i,
    output logic tone_o
);
    localparam int            CW   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [CW-1:0] WRAP = CW'(TONE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tone_q, tone_d;

    always_comb begin
        cnt_d  = '0;
        tone_d = 1'b0;
        if (start_i) begin
            tone_d = 1'b1;
        end else if (en_i) begin
            if (cnt_q == WRAP) begin
                tone_d = ~tone_q;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                tone_d = tone_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = tone_q;
endmodule

// File: rtl/alarm_ringer_ctrl.sv
// Alarm set-point compare and ring controller; RINGER1 carries the tone.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_ringer_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int TONE_DIV    = 4,
    parameter int SNOOZE_SECS = 300
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic              alarm_load,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_min,
    input  logic              stop_btn,
    input  logic              snooze_btn,
    output logic              RINGER1,
    output logic              ringing
);
    localparam logic [7:0] RING_INIT = 8'(RING_SECS);

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic [HOUR_W-1:0] alm_hour_q, alm_hour_d;
    logic [MIN_W-1:0]  alm_min_q, alm_min_d;
    logic [7:0]        ring_cnt_q, ring_cnt_d;
    logic              ringing_q;
    logic              trig;
`ifdef ALARM_SNOOZE_EN
    localparam logic [9:0] SNZ_INIT = 10'(SNOOZE_SECS);
    logic [9:0]        snz_cnt_q, snz_cnt_d;
`else
    logic              unused_snz;
    assign unused_snz = snooze_btn ^ (SNOOZE_SECS > 0);
`endif

    assign trig = armed_q & tick_1hz & (cur_sec == '0) &
                  (cur_hour == alm_hour_q) & (cur_min == alm_min_q);

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        alm_hour_d = alm_hour_q;
        alm_min_d  = alm_min_q;
        ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        // Set-point load is independent of the ring FSM.
        if (alarm_load && set_point_ok(set_hour, set_min)) begin
            armed_d    = 1'b1;
            alm_hour_d = set_hour;
            alm_min_d  = set_min;
        end

        case (state_q)
            IDLE: begin
                if (trig && !stop_btn) begin
                    state_d    = RING;
                    ring_cnt_d = RING_INIT;
                end
            end
            RING: begin
                if (stop_btn) begin
                    state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze_btn) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = SNZ_INIT;
`endif
                end else if (tick_1hz) begin
                    if (ring_cnt_q == 8'd1) state_d = IDLE;
                    ring_cnt_d = ring_cnt_q - 8'd1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (stop_btn) begin
                    state_d = IDLE;
                end else if (tick_1hz) begin
                    if (snz_cnt_q == 10'd1) begin
                        state_d    = RING;
                        ring_cnt_d = RING_INIT;
                    end
                    snz_cnt_d = snz_cnt_q - 10'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            alm_hour_q <= '0;
            alm_min_q  <= '0;
            ring_cnt_q <= '0;
            ringing_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            alm_hour_q <= alm_hour_d;
            alm_min_q  <= alm_min_d;
            ring_cnt_q <= ring_cnt_d;
            ringing_q  <= (state_d == RING);
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
`endif
        end
    end

    // Tone flop is driven from the next state so RINGER1 tracks ringing edge-for-edge.
    alarm_tone_gen #(.TONE_DIV(TONE_DIV)) u_tone (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .en_i    (state_d == RING),
        .start_i ((state_d == RING) && (state_q != RING)),
        .tone_o  (RINGER1)
    );

    assign ringing = ringing_q;
endmodule

// File: tb/tb_alarm_ringer_ctrl.sv
// Scoreboard bench for alarm_ringer_ctrl (RING_SECS=5, TONE_DIV=4, SNOOZE_SECS=3).
module tb_alarm_ringer_ctrl;
    localparam int RS = 5;
    localparam int TD = 4;
    localparam int SS = 3;

    logic       clk = 1'b0;
    logic       reset_n, tick_1hz, alarm_load, stop_btn, snooze_btn;
    logic [4:0] cur_hour, set_hour;
    logic [5:0] cur_min, cur_sec, set_min;
    logic       ringer1, ringing;

    typedef struct {
        logic  ring;
        logic  rgr;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   rk;

    always #5 clk = ~clk;

    alarm_ringer_ctrl #(.RING_SECS(RS), .TONE_DIV(TD), .SNOOZE_SECS(SS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_1hz   (tick_1hz),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alarm_load (alarm_load),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .RINGER1    (ringer1),
        .ringing    (ringing)
    );

    // Monitor: one expectation per clock, sampled 1 time unit after the edge.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (ringing !== mon_e.ring || ringer1 !== mon_e.rgr) begin
                errors++;
                $display("FAIL %s: got ringing=%b RINGER1=%b, want ringing=%b RINGER1=%b",
                         mon_e.tag, ringing, ringer1, mon_e.ring, mon_e.rgr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input logic er, input logic ep, input string tag);
        exp_t e;
        e.ring = er;
        e.rgr  = ep;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #2;
        tick_1hz   = 1'b0;
        alarm_load = 1'b0;
    endtask

    // Ringing cycle: tone is high for TD clocks from ring entry, then low for TD.
    task automatic rstep(input string tag);
        step(1'b1, ((rk / TD) % 2) == 0, tag);
        rk++;
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) step(1'b0, 1'b0, tag);
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hour = h;
        cur_min  = m;
        cur_sec  = s;
    endtask

    task automatic load(input logic [4:0] h, input logic [5:0] m, input string tag);
        set_hour   = h;
        set_min    = m;
        alarm_load = 1'b1;
        step(1'b0, 1'b0, tag);
    endtask

    task automatic trigger(input string tag);
        tick_1hz = 1'b1;
        rk = 0;
        rstep(tag);
    endtask

    // RS ticks spaced gap clocks apart; the last one ends the ring.
    task automatic ring_out(input int gap, input string tag);
        for (int t = 1; t <= RS; t++) begin
            repeat (gap - 1) rstep(tag);
            tick_1hz = 1'b1;
            if (t < RS) rstep(tag);
            else        step(1'b0, 1'b0, {tag, "_end"});
        end
    endtask

    initial begin
        reset_n = 1'b0; tick_1hz = 1'b0; alarm_load = 1'b0;
        stop_btn = 1'b0; snooze_btn = 1'b0;
        set_hour = '0; set_min = '0;
        set_time(5'd0, 6'd0, 6'd0);
        rk = 0;

        step(1'b0, 1'b0, "reset");
        step(1'b0, 1'b0, "reset");
        reset_n = 1'b1;
        // Disarmed after reset even though alm regs match 00:00:00.
        tick_1hz = 1'b1;
        step(1'b0, 1'b0, "disarmed_after_reset");
        idle(1, "idle");

        // 1: basic ring, ticks at a matching time must not restart it
        load(5'd7, 6'd30, "t1_load");
        set_time(5'd7, 6'd29, 6'd59); tick_1hz = 1'b1;
        step(1'b0, 1'b0, "t1_pre_match");
        set_time(5'd7, 6'd30, 6'd0);
        trigger("t1_ring");
        ring_out(6, "t1_ring");
        idle(3, "t1_idle");

        // 2: rings again next day; stop on second tick
        trigger("t2_ring");
        repeat (3) rstep("t2_ring");
        tick_1hz = 1'b1; rstep("t2_tick1");
        repeat (3) rstep("t2_ring");
        tick_1hz = 1'b1; stop_btn = 1'b1;
        step(1'b0, 1'b0, "t2_stop");
        stop_btn = 1'b0;
        idle(2, "t2_idle");
        set_time(5'd7, 6'd30, 6'd1); tick_1hz = 1'b1;
        step(1'b0, 1'b0, "t2_no_retrig");

        // 3: invalid loads dropped, load during ring, new set-point
        load(5'd24, 6'd10, "t3_bad_hour");
        set_time(5'd24, 6'd10, 6'd0); tick_1hz = 1'b1;
        step(1'b0, 1'b0, "t3_no_ring_24h");
        load(5'd12, 6'd60, "t3_bad_min");
        set_time(5'd12, 6'd60, 6'd0); tick_1hz = 1'b1;
        step(1'b0, 1'b0, "t3_no_ring_60m");
        set_time(5'd7, 6'd30, 6'd0);
        trigger("t3_kept_0730");
        repeat (2) rstep("t3_ring");
        set_hour = 5'd23; set_min = 6'd59; alarm_load = 1'b1;
        rstep("t3_load_in_ring");
        rstep("t3_ring");
        stop_btn = 1'b1;
        step(1'b0, 1'b0, "t3_stop");
        stop_btn = 1'b0;
        tick_1hz = 1'b1;
        step(1'b0, 1'b0, "t3_old_setpoint_gone");
        set_time(5'd23, 6'd59, 6'd0);
        trigger("t3_ring_2359");
        repeat (6) rstep("t3_ring_2359");

        // 4: reset mid-ring clears and disarms
        reset_n = 1'b0;
        step(1'b0, 1'b0, "t4_reset_mid_ring");
        reset_n = 1'b1;
        idle(1, "t4_idle");
        set_time(5'd7, 6'd30, 6'd0); tick_1hz = 1'b1;
        step(1'b0, 1'b0, "t4_disarmed_0730");
        set_time(5'd23, 6'd59, 6'd0); tick_1hz = 1'b1;
        step(1'b0, 1'b0, "t4_disarmed_2359");

        // 5: stop and trig on the same cycle
        load(5'd7, 6'd30, "t5_load");
        set_time(5'd7, 6'd30, 6'd0); tick_1hz = 1'b1; stop_btn = 1'b1;
        step(1'b0, 1'b0, "t5_stop_with_trig");
        stop_btn = 1'b0;
        idle(3, "t5_idle");

        // 6: snooze
        trigger("t6_ring");
        repeat (2) rstep("t6_ring");
        snooze_btn = 1'b1;
`ifdef ALARM_SNOOZE_EN
        step(1'b0, 1'b0, "t6_enter_snooze");
        snooze_btn = 1'b0;
        for (int t = 1; t <= SS; t++) begin
            idle(2, "t6_snoozing");
            tick_1hz = 1'b1;
            if (t < SS) step(1'b0, 1'b0, "t6_snooze_tick");
            else        trigger("t6_resume");
        end
        ring_out(3, "t6_resume");
        trigger("t6_ring2");
        rstep("t6_ring2");
        snooze_btn = 1'b1;
        step(1'b0, 1'b0, "t6_enter_snooze2");
        snooze_btn = 1'b0;
        set_time(5'd7, 6'd30, 6'd1);
        tick_1hz = 1'b1;
        step(1'b0, 1'b0, "t6_snooze2_tick");
        stop_btn = 1'b1;
        step(1'b0, 1'b0, "t6_stop_in_snooze");
        stop_btn = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick_1hz = 1'b1;
            step(1'b0, 1'b0, "t6_no_resume");
        end
`else
        repeat (3) rstep("t6_snooze_ignored");
        tick_1hz = 1'b1;
        rstep("t6_snooze_ignored_tick");
        snooze_btn = 1'b0;
        stop_btn = 1'b1;
        step(1'b0, 1'b0, "t6_stop");
        stop_btn = 1'b0;
`endif
        idle(2, "final_idle");

        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
